// File: rtl/seller_param.sv
// Two-product coin seller: latches the product on the first coin, collects credit, then vends with change or refunds.
// Optional macro SELLER_TIMEOUT_EN adds an auto-refund after TIMEOUT_CYC quiet cycles in COLLECT.
module seller_param #(
   parameter int unsigned CREDIT_W    = 4,
   parameter int unsigned PRICE_A     = 3,
   parameter int unsigned PRICE_B     = 5,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                d1,
   input  logic                d2,
   input  logic                d3,
   input  logic                sel,
   input  logic                cancel,
   output logic                out1,
   output logic                out_sel,
   output logic [CREDIT_W-1:0] out2,
   output logic                refund,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   localparam int unsigned PMAX = (PRICE_A > PRICE_B) ? PRICE_A : PRICE_B;
   localparam logic [CREDIT_W-1:0] PA = CREDIT_W'(PRICE_A);
   localparam logic [CREDIT_W-1:0] PB = CREDIT_W'(PRICE_B);

   // Largest possible sum is (price-1)+4, so this bound keeps credit from wrapping.
   if ((PMAX + 3 >= (1 << CREDIT_W)) || (TIMEOUT_CYC == 0)) begin : g_param_check
      $error("seller_param: price/credit width or timeout parameters out of range");
   end

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t                state, state_n;
   logic                  target, target_n;
   logic [CREDIT_W-1:0]   credit_n, out2_n;
   logic                  out1_n, out_sel_n, refund_n;
   logic [CREDIT_W-1:0]   v, sum, price;
   logic                  tgt_eff, coin;

`ifdef SELLER_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   logic [CNT_W-1:0] cnt, cnt_n;
`endif

   // Priority d1 > d2 > d3; lower-priority coins in the same cycle are dropped.
   assign v = d1 ? CREDIT_W'(1) : d2 ? CREDIT_W'(2) : d3 ? CREDIT_W'(4) : '0;
   assign coin    = d1 | d2 | d3;
   assign tgt_eff = (state == IDLE) ? sel : target;
   assign price   = tgt_eff ? PB : PA;
   assign sum     = (state == IDLE) ? v : credit + v;
   assign busy    = (state == COLLECT);

   always_comb begin
      state_n   = state;
      credit_n  = credit;
      target_n  = target;
      out1_n    = 1'b0;
      out_sel_n = 1'b0;
      out2_n    = '0;
      refund_n  = 1'b0;
`ifdef SELLER_TIMEOUT_EN
      cnt_n     = cnt;
`endif
      unique case (state)
         IDLE: begin
            if (coin) begin
               target_n = sel;
               if (sum >= price) begin
                  out1_n    = 1'b1;
                  out_sel_n = tgt_eff;
                  out2_n    = sum - price;
                  credit_n  = '0;
               end else begin
                  state_n  = COLLECT;
                  credit_n = sum;
`ifdef SELLER_TIMEOUT_EN
                  cnt_n    = '0;
`endif
               end
            end
         end
         COLLECT: begin
            if (sum >= price) begin
               out1_n    = 1'b1;
               out_sel_n = tgt_eff;
               out2_n    = sum - price;
               credit_n  = '0;
               state_n   = IDLE;
            end else if (cancel) begin
               refund_n = 1'b1;
               out2_n   = sum;
               credit_n = '0;
               state_n  = IDLE;
            end else if (coin) begin
               credit_n = sum;
`ifdef SELLER_TIMEOUT_EN
               cnt_n    = '0;
`endif
            end
`ifdef SELLER_TIMEOUT_EN
            // Refund on the quiet cycle that would bring the counter to TIMEOUT_CYC.
            else if (cnt == CNT_LAST) begin
               refund_n = 1'b1;
               out2_n   = credit;
               credit_n = '0;
               state_n  = IDLE;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
`endif
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         credit  <= '0;
         target  <= 1'b0;
         out1    <= 1'b0;
         out_sel <= 1'b0;
         out2    <= '0;
         refund  <= 1'b0;
`ifdef SELLER_TIMEOUT_EN
         cnt     <= '0;
`endif
      end else begin
         state   <= state_n;
         credit  <= credit_n;
         target  <= target_n;
         out1    <= out1_n;
         out_sel <= out_sel_n;
         out2    <= out2_n;
         refund  <= refund_n;
`ifdef SELLER_TIMEOUT_EN
         cnt     <= cnt_n;
`endif
      end
   end

endmodule

// File: tb/tb_seller_param.sv
// Scoreboard bench for seller_param: a transaction-level model queues expected status and pulses; a monitor compares.
module tb_seller_param;

   localparam int unsigned CW = 4;
   localparam int unsigned PA = 3;
   localparam int unsigned PB = 5;
   localparam int unsigned TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          d1 = 1'b0, d2 = 1'b0, d3 = 1'b0, sel = 1'b0, cancel = 1'b0;
   logic          out1, out_sel, refund, busy;
   logic [CW-1:0] out2, credit;

   seller_param #(.CREDIT_W(CW), .PRICE_A(PA), .PRICE_B(PB), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .d1(d1), .d2(d2), .d3(d3), .sel(sel), .cancel(cancel),
      .out1(out1), .out_sel(out_sel), .out2(out2), .refund(refund),
      .credit(credit), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {bit o1; bit rf; bit os; int unsigned o2; int unsigned cr; bit bz;} st_t;
   typedef struct {bit vend; bit os; int unsigned amt;} ev_t;

   st_t stq[$];
   ev_t evq[$];
   st_t ms;
   ev_t mev;
   int  checks = 0;
   int  fails  = 0;

   // Transaction-level model: credit held, product chosen, quiet cycles elapsed.
   bit          m_active = 0;
   bit          m_tgt = 0;
   int unsigned m_credit = 0;
   int unsigned m_quiet = 0;

   task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input bit a, input bit b, input bit c, input bit s, input bit cn, input bit r);
      st_t         e;
      int unsigned v, price, sum;
      @(negedge clk);
      d1 = a; d2 = b; d3 = c; sel = s; cancel = cn; rst = r;
      e = '{0, 0, 0, 0, 0, 0};
      v = a ? 1 : b ? 2 : c ? 4 : 0;
      sum = 0;
      if (r) begin
         m_active = 0;
         m_credit = 0;
         m_tgt    = 0;
      end else if (m_active || v != 0) begin
         if (!m_active) begin
            m_tgt = s;
            sum = v;
         end else begin
            sum = m_credit + v;
         end
         price = m_tgt ? PB : PA;
         if (sum >= price) begin
            e.o1 = 1; e.os = m_tgt; e.o2 = sum - price;
            evq.push_back('{1, m_tgt, sum - price});
            m_active = 0; m_credit = 0;
         end else if (m_active && cn) begin
            e.rf = 1; e.o2 = sum;
            evq.push_back('{0, 0, sum});
            m_active = 0; m_credit = 0;
         end else if (v != 0) begin
            m_active = 1; m_credit = sum; m_quiet = 0;
         end else begin
            m_quiet++;
`ifdef SELLER_TIMEOUT_EN
            if (m_quiet == TO) begin
               e.rf = 1; e.o2 = m_credit;
               evq.push_back('{0, 0, m_credit});
               m_active = 0; m_credit = 0;
            end
`endif
         end
      end
      e.cr = m_credit;
      e.bz = m_active;
      stq.push_back(e);
   endtask

   task automatic quiet(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (stq.size() > 0) begin
            ms = stq.pop_front();
            chk("out1", out1, ms.o1);
            chk("refund", refund, ms.rf);
            chk("out2", out2, ms.o2);
            chk("out_sel", out_sel, ms.os);
            chk("credit", credit, ms.cr);
            chk("busy", busy, ms.bz);
            if (out1 || refund) begin
               if (evq.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL unexpected_pulse: out1=%0b refund=%0b with no queued event at %0t", out1, refund, $time);
               end else begin
                  mev = evq.pop_front();
                  chk("pulse_kind", out1, mev.vend);
                  if (mev.vend) chk("pulse_sel", out_sel, mev.os);
                  chk("pulse_amount", out2, mev.amt);
               end
            end
         end
      end
   end

   initial begin
      bit a, b, c, s, cn, r;
      int unsigned rate;
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      quiet(1);
      // Product A exact: d1 then d2.
      step(1, 0, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0); quiet(2);
      // Product B with change; sel flips mid-collect.
      step(0, 0, 1, 1, 0, 0); step(0, 1, 0, 0, 0, 0); quiet(2);
      // Vend beats a same-cycle cancel.
      step(1, 0, 0, 0, 0, 0); step(0, 1, 0, 0, 1, 0); quiet(2);
      // Cancel refunds credit; cancel in IDLE ignored.
      step(0, 1, 0, 1, 0, 0); step(0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 1, 0); quiet(1);
      // Simultaneous coins credit only d1; reset mid-collect drops credit silently.
      step(1, 1, 1, 1, 0, 0); step(0, 0, 0, 0, 0, 1); quiet(2);
      // Coin during the vend pulse starts a new transaction.
      step(0, 1, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0); quiet(2);
      // Cancel together with a coin refunds both.
      step(1, 0, 0, 1, 0, 0); step(0, 1, 0, 0, 1, 0); quiet(2);
`ifdef SELLER_TIMEOUT_EN
      step(0, 1, 0, 1, 0, 0); quiet(16); quiet(2);
      step(0, 1, 0, 1, 0, 0); quiet(14); step(1, 0, 0, 0, 0, 0); quiet(3);
      step(0, 0, 0, 0, 1, 0); quiet(2);
`endif
      for (int i = 0; i < 3000; i++) begin
         rate = ((i / 200) % 2 == 0) ? 3 : 24;
         a  = ($urandom_range(0, rate) == 0);
         b  = ($urandom_range(0, rate) == 0);
         c  = ($urandom_range(0, rate) == 0);
         s  = $urandom_range(0, 1);
         cn = ($urandom_range(0, 9) == 0);
         r  = ($urandom_range(0, 199) == 0);
         step(a, b, c, s, cn, r);
      end
      quiet(3);
      @(posedge clk);
      #3;
      chk("queues_drained", evq.size() + stq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
